branch_ctrl: RTL and testbench
==============================

// Module: branch_ctrl
// PURPOSE
// - Multicycle control slice for fetch, decode, BEQ, J and (optionally) BNE.
// - Drives pc_write_cond into the downstream branch AND gate (ANDed there with ALU zero), plus pc_write and pc_source for the PC mux.
// - Hands every other opcode to the main controller through a req/done handshake.
// PARAMETERS
// - MEM_WAIT  2   extra memory wait cycles in fetch (0..15); fetch lasts MEM_WAIT+1 cycles
// - CNT_W     16  width of retired-instruction counter
// PORTS
// - clk            in   1      clock, rising edge
// - reset_n        in   1      asynchronous active-low reset
// - opcode         in   6      instruction[31:26], valid from DECODE onward
// - exec_done      in   1      main controller finished handed-off instruction
// - pc_write       out  1      unconditional PC load
// - pc_write_cond  out  1      conditional PC load, to branch AND gate
// - invert_zero    out  1      branch gate uses ~zero (BNE)
// - pc_source      out  2      00 ALU result, 01 ALUOut (target), 10 jump address
// - ir_write       out  1      instruction register load
// - mem_read       out  1      instruction memory read
// - alu_src_a      out  1      0 PC, 1 rs
// - alu_src_b      out  2      00 rt, 01 const 4, 11 sign-ext<<2
// - alu_op         out  2      00 add, 01 sub
// - exec_req       out  1      handoff request to main controller
// - instr_count    out  CNT_W  retired instructions, wraps modulo 2^CNT_W
// BEHAVIOUR
// - Moore FSM; outputs decoded from the state register only. Any output not listed for a state is 0.
// - States and transitions:
//   - RST: entered on reset. All outputs 0, instr_count=0. Goes to FETCH on the first clk after reset_n rises.
//   - FETCH: mem_read=1, alu_src_b=01, alu_op=00.
//     - Wait counter loads MEM_WAIT on entry and decrements each cycle.
//     - In the cycle the counter is 0: ir_write=1, pc_write=1, pc_source=00, then go to DECODE.
//   - DECODE: alu_src_b=11, alu_op=00 (branch target into ALUOut). Next state by opcode:
//     - 6'h04 -> BRANCH
//     - 6'h02 -> JUMP
//     - 6'h05 -> BRANCH if BNE_EN, else HANDOFF
//     - any other -> HANDOFF
//   - BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01.
//     - invert_zero=1 only for BNE.
//     - Lasts 1 cycle, then FETCH.
//   - JUMP: pc_write=1, pc_source=10. Lasts 1 cycle, then FETCH.
//   - HANDOFF: exec_req=1 and held while exec_done=0.
//     - exec_done=1 in any HANDOFF cycle -> FETCH next cycle.
//     - exec_done seen in the first HANDOFF cycle -> 1-cycle handoff.
//     - exec_done outside HANDOFF is ignored.
// - instr_count increments by 1 on every exit from BRANCH, JUMP or HANDOFF; it never saturates.
// - Latency: BEQ/J take MEM_WAIT+3 cycles from FETCH entry back to FETCH.
// - reset_n low in any state: outputs are 0 immediately (async); FSM, wait counter and instr_count clear. A fetch in progress is aborted, not completed.
// - An opcode that changes after DECODE has no effect; the path is latched by the state.
// CONFIGURATION
// - BRANCH_CTRL_BNE_EN defined: opcode 6'h05 takes the BRANCH path with invert_zero=1.
// - Not defined: invert_zero is tied 0 and 6'h05 takes the HANDOFF path.
// STRUCTURE
// - Package branch_ctrl_pkg holds:
//   - state_t enum {RST, FETCH, DECODE, BRANCH, JUMP, HANDOFF}
//   - opcode constants OP_BEQ, OP_BNE, OP_J
//   - encodings PCSRC_ALU, PCSRC_ALUOUT, PCSRC_JUMP, ALUOP_ADD, ALUOP_SUB
// - One sub-module, fetch_wait_counter: 4-bit load/decrement counter with a zero flag.
// TESTING
// 1. Reset and fetch (MEM_WAIT=2): reset_n low -> all outputs 0. Release -> RST for 1 cycle, then FETCH with mem_read=1 for 3 cycles; ir_write=pc_write=1 only in the 3rd.
// 2. BEQ (opcode 04): DECODE then BRANCH with pc_write_cond=1, pc_source=01, alu_op=01, invert_zero=0; back to FETCH; instr_count 0 -> 1.
// 3. J (opcode 02): JUMP with pc_write=1, pc_source=10 for exactly 1 cycle.
// 4. Opcode 00 with exec_done held low 4 cycles, then high: exec_req=1 for 5 cycles, then FETCH. Repeat with exec_done already high -> exec_req for 1 cycle.
// 5. Opcode 05: with BRANCH_CTRL_BNE_EN, BRANCH with invert_zero=1; without it, HANDOFF with invert_zero=0.
// 6. reset_n pulsed low mid-FETCH and mid-HANDOFF: outputs 0 asynchronously, instr_count=0, restart from RST. Also preload instr_count to all-ones -> wraps to 0.

Source files
------------

// File: rtl/branch_ctrl_pkg.sv
// Shared types and encodings for the branch_ctrl multicycle control slice.
package branch_ctrl_pkg;

  typedef enum logic [2:0] {
    RST     = 3'd0,
    FETCH   = 3'd1,
    DECODE  = 3'd2,
    BRANCH  = 3'd3,
    JUMP    = 3'd4,
    HANDOFF = 3'd5
  } state_t;

  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_BNE = 6'h05;
  localparam logic [5:0] OP_J   = 6'h02;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_SUB = 2'b01;

  localparam logic [1:0] SRCB_RT   = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b11;

  // True when the opcode is resolved locally as a conditional branch.
  function automatic logic is_branch_op(input logic [5:0] op, input logic bne_en);
    return (op == OP_BEQ) || (bne_en && (op == OP_BNE));
  endfunction

endpackage

// File: rtl/branch_ctrl_fetch_wait.sv
// fetch_wait_counter: 4-bit load/decrement counter that paces instruction fetch.
module fetch_wait_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       dec,
  input  logic [3:0] load_val,
  output logic       zero
);

  logic [3:0] cnt_r;

  // Load takes priority; decrement stops at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= 4'd0;
    end else if (load) begin
      cnt_r <= load_val;
    end else if (dec && (cnt_r != 4'd0)) begin
      cnt_r <= cnt_r - 4'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign zero = (cnt_r == 4'd0);

endmodule

// File: rtl/branch_ctrl.sv
// branch_ctrl: Moore control FSM for fetch/decode/BEQ/J with handoff of other opcodes.
// Optional BNE support is enabled by defining BRANCH_CTRL_BNE_EN.
module branch_ctrl
  import branch_ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 2,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [5:0]       opcode,
  input  logic             exec_done,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             invert_zero,
  output logic [1:0]       pc_source,
  output logic             ir_write,
  output logic             mem_read,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             exec_req,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [3:0] WAIT_INIT = 4'(MEM_WAIT);

  state_t           state_r;
  state_t           next_state_s;
  logic             wait_zero_s;
  logic             wait_load_s;
  logic             retire_s;
  logic             bne_s;
  logic [CNT_W-1:0] count_r;

`ifdef BRANCH_CTRL_BNE_EN
  localparam logic BNE_EN = 1'b1;
  logic bne_r;

  // Remember which branch flavour was decoded so BRANCH can drive invert_zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bne_r <= 1'b0;
    end else if (state_r == DECODE) begin
      bne_r <= (opcode == OP_BNE);
    end else begin
      bne_r <= bne_r;
    end
  end

  assign bne_s = bne_r;
`else
  localparam logic BNE_EN = 1'b0;
  assign bne_s = 1'b0;
`endif

  assign wait_load_s = (next_state_s == FETCH) && (state_r != FETCH);
  assign retire_s    = (state_r == BRANCH) || (state_r == JUMP) ||
                       ((state_r == HANDOFF) && exec_done);

  fetch_wait_counter u_fetch_wait (
    .clk      (clk),
    .rst_n    (reset_n),
    .load     (wait_load_s),
    .dec      (state_r == FETCH),
    .load_val (WAIT_INIT),
    .zero     (wait_zero_s)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= RST;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Retired-instruction counter, wraps freely.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_r <= {CNT_W{1'b0}};
    end else if (retire_s) begin
      count_r <= count_r + CNT_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign instr_count = count_r;

  // Next-state decode; the taken path is latched in the state at DECODE exit.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      RST:     next_state_s = FETCH;
      FETCH:   next_state_s = wait_zero_s ? DECODE : FETCH;
      DECODE: begin
        if (is_branch_op(opcode, BNE_EN)) begin
          next_state_s = BRANCH;
        end else if (opcode == OP_J) begin
          next_state_s = JUMP;
        end else begin
          next_state_s = HANDOFF;
        end
      end
      BRANCH:  next_state_s = FETCH;
      JUMP:    next_state_s = FETCH;
      HANDOFF: next_state_s = exec_done ? FETCH : HANDOFF;
      default: next_state_s = RST;
    endcase
  end

  // Moore output decode from registered state only.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    invert_zero   = 1'b0;
    pc_source     = PCSRC_ALU;
    ir_write      = 1'b0;
    mem_read      = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_RT;
    alu_op        = ALUOP_ADD;
    exec_req      = 1'b0;
    case (state_r)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        alu_op    = ALUOP_ADD;
        if (wait_zero_s) begin
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          pc_source = PCSRC_ALU;
        end else begin
          ir_write  = 1'b0;
          pc_write  = 1'b0;
        end
      end
      DECODE: begin
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_ADD;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        alu_src_b     = SRCB_RT;
        alu_op        = ALUOP_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
        invert_zero   = bne_s;
      end
      JUMP: begin
        pc_write  = 1'b1;
        pc_source = PCSRC_JUMP;
      end
      HANDOFF: exec_req = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_branch_ctrl.sv
// Self-checking bench for branch_ctrl: per-cycle expectation queue from an instruction-level model.
module tb_branch_ctrl;

  localparam int MEM_WAIT = 2;
  localparam int CNT_W    = 4;
`ifdef BRANCH_CTRL_BNE_EN
  localparam bit BNE_EN = 1'b1;
`else
  localparam bit BNE_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [5:0]       opcode = 6'h00;
  logic             exec_done = 1'b0;
  logic             pc_write, pc_write_cond, invert_zero, ir_write, mem_read, alu_src_a, exec_req;
  logic [1:0]       pc_source, alu_src_b, alu_op;
  logic [CNT_W-1:0] instr_count;

  branch_ctrl #(.MEM_WAIT(MEM_WAIT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .exec_done(exec_done),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .invert_zero(invert_zero),
    .pc_source(pc_source), .ir_write(ir_write), .mem_read(mem_read),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .exec_req(exec_req), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [12:0]      vec;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t             exp_q[$];
  logic [CNT_W-1:0] cnt_m = '0;
  int               checks = 0;
  int               errors = 0;
  int               req_run = 0;

  wire [12:0] act_vec = {pc_write, pc_write_cond, invert_zero, pc_source, ir_write,
                         mem_read, alu_src_a, alu_src_b, alu_op, exec_req};

  function automatic logic [12:0] mk(input logic pw, input logic pwc, input logic iz,
                                     input logic [1:0] ps, input logic irw, input logic mr,
                                     input logic asa, input logic [1:0] asb,
                                     input logic [1:0] aop, input logic req);
    return {pw, pwc, iz, ps, irw, mr, asa, asb, aop, req};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Single compare process: one expected record per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("outputs", 32'(act_vec), 32'(e.vec));
      check("instr_count", 32'(instr_count), 32'(e.cnt));
    end
    req_run = exec_req ? req_run + 1 : 0;
  end

  task automatic cyc(input logic [12:0] v, input logic [5:0] op, input logic done);
    @(posedge clk);
    #1;
    opcode    = op;
    exec_done = done;
    exp_q.push_back('{vec: v, cnt: cnt_m});
  endtask

  // One instruction from FETCH entry; stop_at >= 0 truncates after that many cycles.
  task automatic run_instr(input logic [5:0] op, input int n_wait, input int stop_at);
    int   k;
    logic br, jp;
    k  = 0;
    br = (op == 6'h04) || (BNE_EN && (op == 6'h05));
    jp = (op == 6'h02);
    for (int i = 0; i <= MEM_WAIT; i++) begin
      if (k == stop_at) return;
      cyc(mk(i == MEM_WAIT, 1'b0, 1'b0, 2'b00, i == MEM_WAIT, 1'b1, 1'b0, 2'b01, 2'b00, 1'b0),
          6'h3f ^ 6'(i), 1'b1);
      k++;
    end
    if (k == stop_at) return;
    cyc(mk(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 1'b0), op, 1'b1);
    k++;
    if (br) begin
      if (k == stop_at) return;
      cyc(mk(1'b0, 1'b1, op == 6'h05, 2'b01, 1'b0, 1'b0, 1'b1, 2'b00, 2'b01, 1'b0), 6'h02, 1'b1);
      cnt_m = cnt_m + 1'b1;
    end else if (jp) begin
      if (k == stop_at) return;
      cyc(mk(1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0), 6'h04, 1'b1);
      cnt_m = cnt_m + 1'b1;
    end else begin
      for (int w = 0; w <= n_wait; w++) begin
        if (k == stop_at) return;
        cyc(mk(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1), 6'h02, w == n_wait);
        k++;
      end
      cnt_m = cnt_m + 1'b1;
    end
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    exp_q.push_back('{vec: 13'd0, cnt: cnt_m});
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    cnt_m   = '0;
    #1;
    check("async_outputs_zero", 32'(act_vec), 32'd0);
    check("async_count_zero", 32'(instr_count), 32'd0);
    exp_q.push_back('{vec: 13'd0, cnt: cnt_m});
    release_reset();
  endtask

  initial begin
    #3;
    check("reset_outputs_zero", 32'(act_vec), 32'd0);
    check("reset_count_zero", 32'(instr_count), 32'd0);
    release_reset();

    run_instr(6'h04, 0, -1);
    run_instr(6'h02, 0, -1);
    check("jump_pc_source", 32'(pc_source), 32'h2);
    check("jump_pc_write", 32'(pc_write), 32'h1);
    check("count_after_beq", 32'(instr_count), 32'h1);

    run_instr(6'h00, 4, -1);
    @(negedge clk);
    #1;
    check("handoff_len_5", 32'(req_run), 32'd5);
    run_instr(6'h00, 0, -1);
    @(negedge clk);
    #1;
    check("handoff_len_1", 32'(req_run), 32'd1);

    run_instr(6'h05, 1, -1);
    run_instr(6'h2b, 2, -1);
    run_instr(6'h04, 0, 2);
    do_reset();
    run_instr(6'h04, 0, -1);
    run_instr(6'h23, 5, 6);
    do_reset();

    for (int n = 0; n < 15; n++) run_instr(6'h02, 0, -1);
    run_instr(6'h02, 0, -1);
    check("count_all_ones", 32'(instr_count), 32'hF);
    run_instr(6'h04, 0, 1);
    check("count_wrapped", 32'(instr_count), 32'h0);

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
